// File: rtl/pulse_generator.sv
// ---------------------------------------------------------------------------
// pulse_generator
//   Fixed-period PWM source. A PERIOD-cycle frame counter is compared
//   against a duty threshold of mode*(PERIOD/4). The result is registered,
//   so pwm is high for exactly thr cycles per frame, starting at cnt=0.
//   Selectable duties are 0%, 25%, 50% and 75%. 100% cannot be selected.
//
// Parameters
//   PERIOD : frame length in clk cycles. Must be a multiple of 4 and >= 4.
//
// Ports
//   clk  : system clock, rising-edge active
//   rst  : synchronous active-high reset (clears cnt, thr and pwm)
//   mode : duty select, 0=0%, 1=25%, 2=50%, 3=75%
//   pwm  : registered PWM output, active high
//
// Build option
//   PULSE_GEN_FRAME_SYNC_EN
//     When defined, mode is sampled into thr only at frame end
//     (cnt==PERIOD-1), so every frame is a complete duty cycle.
//     When undefined, thr follows mode every cycle (1-cycle latency).
//     The current frame may then be truncated or extended once.
// ---------------------------------------------------------------------------
module pulse_generator #(
  parameter int PERIOD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] mode,
  output logic       pwm
);

  localparam int CNT_W = $clog2(PERIOD);
  // One extra bit keeps mode*(PERIOD/4) from overflowing.
  localparam int THR_W = CNT_W + 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);
  localparam logic [THR_W-1:0] QUARTER  = THR_W'(PERIOD / 4);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [THR_W-1:0] thr_q, thr_d;
  logic             pwm_q, pwm_d;
  logic [THR_W-1:0] mode_thr;
  logic             frame_end;

  always_comb begin
    frame_end = (cnt_q == CNT_LAST);
    mode_thr  = THR_W'(mode) * QUARTER;

    // Free-running frame counter. It wraps and has no terminal stall.
    cnt_d = frame_end ? '0 : cnt_q + CNT_W'(1);

`ifdef PULSE_GEN_FRAME_SYNC_EN
    // Latch the new duty only as the frame closes.
    // The next frame is then a whole, unmodified cycle.
    thr_d = frame_end ? mode_thr : thr_q;
`else
    thr_d = mode_thr;
`endif

    // Compare the *next* count against the *next* threshold.
    // This keeps the registered output aligned with cnt_q.
    // At cnt=0 the output is high whenever thr is non-zero.
    pwm_d = ({1'b0, cnt_d} < thr_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      thr_q <= '0;
      pwm_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      thr_q <= thr_d;
      pwm_q <= pwm_d;
    end
  end

  assign pwm = pwm_q;

endmodule

// File: tb/tb_pulse_generator.sv
// ---------------------------------------------------------------------------
// tb_pulse_generator
//   Directed bench for pulse_generator with PERIOD=16 and a 2 ns clock.
//   The bench tracks the frame phase from its own reset/cycle bookkeeping.
//   Each checked frame is captured as a 16-bit high-cycle mask, together
//   with its rise and fall counts. These are compared against
//   hand-computed values.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pulse_generator;

  localparam int PERIOD = 16;

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic [1:0] mode = 2'd0;
  logic       pwm;

  int n_cmp  = 0;
  int n_bad  = 0;
  int phase  = 0;
  int n_x    = 0;
  int n_rise = 0;
  int n_fall = 0;
  logic last_pwm = 1'b0;

  pulse_generator #(.PERIOD(PERIOD)) dut (
    .clk  (clk),
    .rst  (rst),
    .mode (mode),
    .pwm  (pwm)
  );

  always #1 clk = ~clk;

  typedef struct {
    logic [1:0] mode;
    int         settle;
    int         meas;
    int         exp_high;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock cycle. The bench tracks the counter phase from the rst it
  // applied. pwm is sampled on the falling edge.
  task automatic cyc();
    logic r;
    r = rst;
    @(posedge clk);
    phase = r ? 0 : (phase + 1) % PERIOD;
    @(negedge clk);
    if ($isunknown(pwm)) n_x++;
    if (pwm === 1'b1 && last_pwm === 1'b0) n_rise++;
    if (pwm === 1'b0 && last_pwm === 1'b1) n_fall++;
    last_pwm = pwm;
  endtask

  // Advance to phase PERIOD-1, then capture one full frame (phases 0..15).
  // The caller may request a mode change right after phase chg_phase.
  task automatic run_frame(input string tag, input bit chk,
                           input int exp_mask, input int exp_rise,
                           input int exp_fall, input int chg_phase,
                           input logic [1:0] chg_mode);
    int mask, r0, f0, x0, guard;
    guard = 0;
    while (phase != PERIOD - 1 && guard < PERIOD) begin
      cyc();
      guard++;
    end
    if (chk) check({tag, "_align"}, phase, PERIOD - 1);
    mask = 0;
    r0 = n_rise;
    f0 = n_fall;
    x0 = n_x;
    for (int i = 0; i < PERIOD; i++) begin
      cyc();
      if (pwm === 1'b1) mask |= (1 << phase);
      if (phase == chg_phase) mode = chg_mode;
    end
    if (chk) begin
      check({tag, "_mask"}, mask, exp_mask);
      check({tag, "_rise"}, n_rise - r0, exp_rise);
      check({tag, "_fall"}, n_fall - f0, exp_fall);
      check({tag, "_x"}, n_x - x0, 0);
    end
  endtask

  initial begin
    vec_t vecs[8];
    int   hc, guard, em;

    vecs[0] = '{mode: 2'd1, settle: 1, meas: 8, exp_high: 4};
    vecs[1] = '{mode: 2'd2, settle: 1, meas: 8, exp_high: 8};
    vecs[2] = '{mode: 2'd3, settle: 1, meas: 8, exp_high: 12};
    vecs[3] = '{mode: 2'd0, settle: 1, meas: 8, exp_high: 0};
    vecs[4] = '{mode: 2'd3, settle: 1, meas: 3, exp_high: 12};
    vecs[5] = '{mode: 2'd1, settle: 1, meas: 3, exp_high: 4};
    vecs[6] = '{mode: 2'd2, settle: 1, meas: 3, exp_high: 8};
    vecs[7] = '{mode: 2'd0, settle: 1, meas: 3, exp_high: 0};

    // Reset with mode 0: pwm low during reset and for 3+ frames after.
    rst = 1'b1;
    mode = 2'd0;
    cyc();
    check("rst_cyc0_pwm", int'(pwm), 0);
    cyc();
    check("rst_cyc1_pwm", int'(pwm), 0);
    rst = 1'b0;
    for (int f = 0; f < 3; f++)
      run_frame($sformatf("idle_f%0d", f), 1'b1, 0, 0, 0, -1, 2'd0);

    // Steady-state duty table: 25/50/75/0 sweep with ~150-cycle dwell,
    // then a second, shorter out-of-order pass.
    for (int v = 0; v < 8; v++) begin
      mode = vecs[v].mode;
      em = (1 << vecs[v].exp_high) - 1;
      for (int s = 0; s < vecs[v].settle; s++)
        run_frame("settle", 1'b0, 0, 0, 0, -1, 2'd0);
      for (int m = 0; m < vecs[v].meas; m++)
        run_frame($sformatf("v%0d_m%0d_f%0d", v, vecs[v].mode, m), 1'b1, em,
                  (vecs[v].exp_high != 0) ? 1 : 0,
                  (vecs[v].exp_high != 0) ? 1 : 0, -1, 2'd0);
    end

    // Mode 3 -> 1 at cnt=6.
    mode = 2'd3;
    run_frame("sw_pre", 1'b1, 16'h0fff, 1, 1, -1, 2'd0);
`ifdef PULSE_GEN_FRAME_SYNC_EN
    run_frame("sw_cur", 1'b1, 16'h0fff, 1, 1, 6, 2'd1);
`else
    run_frame("sw_cur", 1'b1, 16'h007f, 1, 1, 6, 2'd1);
`endif
    run_frame("sw_next", 1'b1, 16'h000f, 1, 1, -1, 2'd0);

    // Five-cycle reset in mid-frame with mode 3.
    mode = 2'd3;
    run_frame("mr_pre", 1'b1, 16'h0fff, 1, 1, -1, 2'd0);
    guard = 0;
    while (phase != 5 && guard < PERIOD) begin
      cyc();
      guard++;
    end
    check("mr_phase", phase, 5);
    check("mr_pwm_before", int'(pwm), 1);
    rst = 1'b1;
    cyc();
    check("mr_pwm_next_edge", int'(pwm), 0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      check($sformatf("mr_pwm_hold%0d", i), int'(pwm), 0);
    end
    rst = 1'b0;
    // The cnt=0 cycle of the first post-reset frame still shows the reset
    // value. The free-running build recovers from cnt=1. The frame-sync
    // build stays low until thr is sampled at the frame end.
    hc = 0;
    for (int i = 0; i < PERIOD - 1; i++) begin
      cyc();
      if (pwm === 1'b1) hc++;
    end
`ifdef PULSE_GEN_FRAME_SYNC_EN
    check("mr_first_frame_high", hc, 0);
`else
    check("mr_first_frame_high", hc, 11);
`endif
    run_frame("mr_post", 1'b1, 16'h0fff, 1, 1, -1, 2'd0);

    check("x_total", n_x, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
